dds_phase_ctrl: RTL and testbench

DDS_PHASE_CTRL -- requirements
Module: dds_phase_ctrl

---
 rtl/dds_pkg.sv | 18 +
 rtl/dds_phase_acc.sv | 36 +++
 rtl/dds_phase_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dds_phase_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, state encoding and small helpers for the DDS phase controller.
package dds_pkg;

    localparam int ACC_W  = 32;
    localparam int ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } dds_state_t;

    // True while the accumulator is advancing (a new tuning word may be pending).
    function automatic logic st_active(input dds_state_t s);
        return (s == ST_RUN) || (s == ST_PEND);
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator register with carry-out and the upper phase bits of the next value.
module dds_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ACC_W-1:0]  ftw,
    output logic [ADDR_W-1:0] phase_next,
    output logic              carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // One-bit-wider add exposes the carry-out of acc + ftw.
    always_comb begin
        sum        = {1'b0, acc} + {1'b0, ftw};
        phase_next = sum[ACC_W-1 -: ADDR_W];
        carry      = sum[ACC_W];
    end

    // Accumulator register; synchronous clear takes priority over advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/dds_phase_ctrl.sv
// DDS phase controller: accumulator-driven LUT address generation with
// phase-continuous (carry-aligned) tuning-word updates via shadow registers.
module dds_phase_ctrl #(
    parameter int ACC_W   = dds_pkg::ACC_W,
    parameter int ADDR_W  = dds_pkg::ADDR_W,
    parameter int LUT_LAT = 1
) (
    input  logic              Fg_CLK,
    input  logic              RESET,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ADDR_W-1:0] cfg_poff,
    output logic [ADDR_W-1:0] Address,
    output logic              addr_valid,
    output logic              lut_valid,
    output logic              wrap,
    output logic [1:0]        state_o
);

    import dds_pkg::*;

    dds_state_t        state;
    logic [ACC_W-1:0]  ftw_a;
    logic [ACC_W-1:0]  ftw_s;
    logic [ADDR_W-1:0] poff_a;
    logic [ADDR_W-1:0] poff_s;
    logic [LUT_LAT-1:0] lut_sr;

    logic [ADDR_W-1:0] phase_next;
    logic              carry;
    logic              xfer;
    logic              apply;
    logic              acc_en;
    logic              acc_clr;

    // Handshake and accumulator control. The shadow is applied on a carry edge,
    // or immediately when the active tuning word is zero (no carry would ever come).
    always_comb begin
        xfer    = cfg_valid & cfg_ready;
        apply   = (state == ST_PEND) && run && (carry || (ftw_a == '0));
        acc_en  = st_active(state) && run;
        acc_clr = !st_active(state) || !run || apply;
    end

    dds_phase_acc #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_acc (
        .clk        (Fg_CLK),
        .rst        (RESET),
        .clr        (acc_clr),
        .en         (acc_en),
        .ftw        (ftw_a),
        .phase_next (phase_next),
        .carry      (carry)
    );

    // Control FSM with registered outputs; Address always tracks the value acc takes on this edge.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            ftw_a      <= '0;
            poff_a     <= '0;
            ftw_s      <= '0;
            poff_s     <= '0;
            Address    <= '0;
            addr_valid <= 1'b0;
            wrap       <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wrap      <= 1'b0;
                    cfg_ready <= 1'b1;
                    if (xfer) begin
                        ftw_a  <= cfg_ftw;
                        poff_a <= cfg_poff;
                    end
                    if (run) begin
                        state      <= ST_RUN;
                        Address    <= xfer ? cfg_poff : poff_a;
                        addr_valid <= 1'b1;
                    end else begin
                        Address    <= '0;
                        addr_valid <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        Address    <= '0;
                        addr_valid <= 1'b0;
                        wrap       <= 1'b0;
                        cfg_ready  <= 1'b1;
                        if (xfer) begin
                            ftw_a  <= cfg_ftw;
                            poff_a <= cfg_poff;
                        end
                    end else begin
                        Address    <= phase_next + poff_a;
                        addr_valid <= 1'b1;
                        wrap       <= carry;
                        if (xfer) begin
                            ftw_s     <= cfg_ftw;
                            poff_s    <= cfg_poff;
                            state     <= ST_PEND;
                            cfg_ready <= 1'b0;
                        end else begin
                            cfg_ready <= 1'b1;
                        end
                    end
                end

                ST_PEND: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        ftw_s      <= '0;
                        poff_s     <= '0;
                        Address    <= '0;
                        addr_valid <= 1'b0;
                        wrap       <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (apply) begin
                        // acc restarts at 0, so the new phase starts exactly at poff_s.
                        state      <= ST_RUN;
                        ftw_a      <= ftw_s;
                        poff_a     <= poff_s;
                        Address    <= poff_s;
                        addr_valid <= 1'b1;
                        wrap       <= carry;
                        cfg_ready  <= 1'b1;
                    end else begin
                        Address    <= phase_next + poff_a;
                        addr_valid <= 1'b1;
                        wrap       <= 1'b0;
                        cfg_ready  <= 1'b0;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    Address    <= '0;
                    addr_valid <= 1'b0;
                    wrap       <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            endcase
        end
    end

    // LUT_LAT-stage delay of addr_valid marking valid lookup-table data.
    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            lut_sr <= '0;
        end else begin
            lut_sr[0] <= addr_valid;
            for (int unsigned i = 1; i < LUT_LAT; i++) begin
                lut_sr[i] <= lut_sr[i-1];
            end
        end
    end

    // Output views of internal state.
    always_comb begin
        lut_valid = lut_sr[LUT_LAT-1];
        state_o   = state;
    end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed scoreboard bench for dds_phase_ctrl.
module tb_dds_phase_ctrl;

    localparam int ACC_W  = 32;
    localparam int ADDR_W = 11;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              av;
        logic              lv;
        logic              wr;
        logic              cr;
        logic [1:0]        st;
    } obs_t;

    logic              Fg_CLK_tb = 1'b0;
    logic              RESET     = 1'b1;
    logic              run       = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_ftw   = '0;
    logic [ADDR_W-1:0] cfg_poff  = '0;
    logic [ADDR_W-1:0] Address;
    logic              addr_valid;
    logic              lut_valid;
    logic              wrap;
    logic [1:0]        state_o;

    obs_t exp_q[$];
    logic last_av = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    dds_phase_ctrl #(
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W),
        .LUT_LAT (1)
    ) dut (
        .Fg_CLK     (Fg_CLK_tb),
        .RESET      (RESET),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ftw    (cfg_ftw),
        .cfg_poff   (cfg_poff),
        .Address    (Address),
        .addr_valid (addr_valid),
        .lut_valid  (lut_valid),
        .wrap       (wrap),
        .state_o    (state_o)
    );

    always #5 Fg_CLK_tb = ~Fg_CLK_tb;

    task automatic compare(input string tag, input obs_t e);
        obs_t o;
        o = '{addr: Address, av: addr_valid, lv: lut_valid, wr: wrap, cr: cfg_ready, st: state_o};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed addr=%0d av=%b lv=%b wrap=%b rdy=%b st=%0d, expected addr=%0d av=%b lv=%b wrap=%b rdy=%b st=%0d",
                   tag, o.addr, o.av, o.lv, o.wr, o.cr, o.st, e.addr, e.av, e.lv, e.wr, e.cr, e.st);
        end
    endtask

    // Push the expectation for the next cycle, advance one edge, then pop and compare.
    task automatic tick_exp(input string tag, input int addr, input logic av,
                            input logic wr, input logic cr, input logic [1:0] st);
        obs_t e;
        e.addr  = addr[ADDR_W-1:0];
        e.av    = av;
        e.lv    = last_av;
        e.wr    = wr;
        e.cr    = cr;
        e.st    = st;
        last_av = av;
        exp_q.push_back(e);
        @(posedge Fg_CLK_tb);
        #1;
        if (exp_q.size() > 0) compare(tag, exp_q.pop_front());
    endtask

    task automatic drive_cfg(input logic v, input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] p);
        cfg_valid = v;
        cfg_ftw   = f;
        cfg_poff  = p;
    endtask

    initial begin
        // Reset held from time 0, then released mid-cycle.
        #12;
        compare("reset_hold", '0);
        RESET = 1'b0;
        tick_exp("idle_after_reset", 0, 0, 0, 1, 0);

        // Linear sweep: one address step per cycle, wrap on the return to 0.
        drive_cfg(1, 32'h0020_0000, 11'd0);
        tick_exp("sweep_cfg", 0, 0, 0, 1, 0);
        drive_cfg(0, '0, '0);
        run = 1'b1;
        for (int k = 0; k < 2050; k++) begin
            tick_exp("sweep", k % 2048, 1, (k == 2048), 1, 1);
        end
        run = 1'b0;
        tick_exp("sweep_stop", 0, 0, 0, 1, 0);

        // Offset wrap: address wraps without an accumulator carry.
        drive_cfg(1, 32'h0020_0000, 11'd2047);
        tick_exp("poff_cfg", 0, 0, 0, 1, 0);
        drive_cfg(0, '0, '0);
        run = 1'b1;
        tick_exp("poff_k0", 2047, 1, 0, 1, 1);
        tick_exp("poff_k1", 0, 1, 0, 1, 1);
        tick_exp("poff_k2", 1, 1, 0, 1, 1);
        tick_exp("poff_k3", 2, 1, 0, 1, 1);
        run = 1'b0;
        tick_exp("poff_stop", 0, 0, 0, 1, 0);

        // Phase-continuous update applied at the accumulator carry.
        drive_cfg(1, 32'h4000_0000, 11'd0);
        tick_exp("pc_cfg", 0, 0, 0, 1, 0);
        drive_cfg(0, '0, '0);
        run = 1'b1;
        tick_exp("pc_k0", 0, 1, 0, 1, 1);
        tick_exp("pc_k1", 512, 1, 0, 1, 1);
        drive_cfg(1, 32'h8000_0000, 11'd0);
        tick_exp("pc_k2", 1024, 1, 0, 0, 2);
        drive_cfg(0, '0, '0);
        tick_exp("pc_k3", 1536, 1, 0, 0, 2);
        tick_exp("pc_k4", 0, 1, 1, 1, 1);
        tick_exp("pc_k5", 1024, 1, 0, 1, 1);
        tick_exp("pc_k6", 0, 1, 1, 1, 1);
        tick_exp("pc_k7", 1024, 1, 0, 1, 1);
        run = 1'b0;
        tick_exp("pc_stop", 0, 0, 0, 1, 0);

        // Stop while pending: shadow discarded, old tuning word kept.
        run = 1'b1;
        tick_exp("sp_k0", 0, 1, 0, 1, 1);
        tick_exp("sp_k1", 1024, 1, 0, 1, 1);
        drive_cfg(1, 32'h0020_0000, 11'd0);
        tick_exp("sp_pend", 0, 1, 1, 0, 2);
        drive_cfg(0, '0, '0);
        run = 1'b0;
        tick_exp("sp_idle", 0, 0, 0, 1, 0);
        run = 1'b1;
        tick_exp("sp_re_k0", 0, 1, 0, 1, 1);
        tick_exp("sp_re_k1", 1024, 1, 0, 1, 1);
        tick_exp("sp_re_k2", 0, 1, 1, 1, 1);
        run = 1'b0;
        tick_exp("sp_stop", 0, 0, 0, 1, 0);

        // Zero tuning word: shadow applied one cycle after entering PEND.
        drive_cfg(1, 32'h0000_0000, 11'd0);
        tick_exp("zt_cfg", 0, 0, 0, 1, 0);
        drive_cfg(0, '0, '0);
        run = 1'b1;
        tick_exp("zt_k0", 0, 1, 0, 1, 1);
        tick_exp("zt_k1", 0, 1, 0, 1, 1);
        drive_cfg(1, 32'h0020_0000, 11'd0);
        tick_exp("zt_pend", 0, 1, 0, 0, 2);
        drive_cfg(0, '0, '0);
        tick_exp("zt_apply", 0, 1, 0, 1, 1);
        tick_exp("zt_inc1", 1, 1, 0, 1, 1);
        tick_exp("zt_inc2", 2, 1, 0, 1, 1);
        tick_exp("zt_inc3", 3, 1, 0, 1, 1);

        // Transfer on the same edge as run=0 loads the active registers directly.
        drive_cfg(1, 32'h4000_0000, 11'd3);
        run = 1'b0;
        tick_exp("cs_idle", 0, 0, 0, 1, 0);
        drive_cfg(0, '0, '0);
        run = 1'b1;
        tick_exp("cs_k0", 3, 1, 0, 1, 1);
        tick_exp("cs_k1", 515, 1, 0, 1, 1);
        tick_exp("cs_k2", 1027, 1, 0, 1, 1);
        tick_exp("cs_k3", 1539, 1, 0, 1, 1);
        tick_exp("cs_k4", 3, 1, 1, 1, 1);

        // Asynchronous reset mid-RUN, observed before any clock edge.
        RESET = 1'b1;
        #2;
        compare("reset_async", '0);
        last_av = 1'b0;
        tick_exp("reset_edge", 0, 0, 0, 0, 0);
        run   = 1'b0;
        RESET = 1'b0;
        tick_exp("reset_release", 0, 0, 0, 1, 0);
        run = 1'b1;
        tick_exp("reset_re_k0", 0, 1, 0, 1, 1);
        tick_exp("reset_re_k1", 0, 1, 0, 1, 1);
        run = 1'b0;
        tick_exp("reset_re_stop", 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
